// File: rtl/spart.sv
// ---------------------------------------------------------------------------
// spart -- special-purpose asynchronous receiver/transmitter (8N1, 16x
// oversampling) sitting behind the processor-side bus driver.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-high reset
//   iocs     chip select; a bus access happens on every rising edge with iocs=1
//   iorw     1 = read (SPART drives databus), 0 = write (driver drives databus)
//   ioaddr   register select
//              write: 00 tx buffer, 10 DB[7:0], 11 DB[15:8] (01 ignored)
//              read : 00 rx buffer, 01 status {5'b0, overrun, tbr, rda},
//                     others 8'h00
//   databus  shared bidirectional data bus, driven only during reads
//   rda      receive data available
//   tbr      transmit buffer ready
//   txd      serial transmit line, idles high
//   rxd      serial receive line, asynchronous to clk
//
// Bus handshake: there is no valid/ready pair on the bus side. Every rising
// edge with iocs=1 is one access; read data is combinational from ioaddr in
// the same cycle and the driver captures it on the edge that ends the cycle.
// Side effects (rda/overrun clear, tx load) happen on every such edge, so a
// held strobe repeats them, which is harmless because each is idempotent.
// ---------------------------------------------------------------------------
module spart #(
   parameter logic [15:0] DB_RESET = 16'h0515
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} fsm_t;

   // ---------------- bus decode ----------------
   logic       rd_en, wr_en;
   logic       wr_tx, wr_dbl, wr_dbh, rd_rx, rd_st;
   logic [7:0] rdata;

   assign rd_en  = iocs & iorw;
   assign wr_en  = iocs & ~iorw;
   assign wr_tx  = wr_en && (ioaddr == 2'b00);
   assign wr_dbl = wr_en && (ioaddr == 2'b10);
   assign wr_dbh = wr_en && (ioaddr == 2'b11);
   assign rd_rx  = rd_en && (ioaddr == 2'b00);
   assign rd_st  = rd_en && (ioaddr == 2'b01);

   // ---------------- baud generator ----------------
   logic [15:0] db;
   logic [15:0] baud_cnt;
   logic        baud_en;

   assign baud_en = (baud_cnt == 16'd0);

   // A divisor write reloads the counter with the new full divisor so the
   // new rate starts cleanly from that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         db       <= DB_RESET;
         baud_cnt <= DB_RESET;
      end else if (wr_dbl) begin
         db[7:0]  <= databus;
         baud_cnt <= {db[15:8], databus};
      end else if (wr_dbh) begin
         db[15:8] <= databus;
         baud_cnt <= {databus, db[7:0]};
      end else if (baud_en) begin
         baud_cnt <= db;
      end else begin
         baud_cnt <= baud_cnt - 16'd1;
      end
   end

   // ---------------- transmitter ----------------
   fsm_t       tx_state, tx_next;
   logic [3:0] tx_tick;
   logic [2:0] tx_bits;
   logic [7:0] tx_shift;
   logic       tx_last;

   // One bit period ends on the 16th enable.
   assign tx_last = baud_en && (tx_tick == 4'hF);

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (wr_tx && tbr)                 tx_next = S_START;
         S_START: if (tx_last)                      tx_next = S_DATA;
         S_DATA:  if (tx_last && tx_bits == 3'd7)   tx_next = S_STOP;
         S_STOP:  if (tx_last)                      tx_next = S_IDLE;
         default:                                   tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_tick  <= 4'd0;
         tx_bits  <= 3'd0;
         tx_shift <= 8'd0;
         tbr      <= 1'b1;
      end else begin
         tx_state <= tx_next;
         if (tx_state == S_IDLE) begin
            tx_tick <= 4'd0;
            tx_bits <= 3'd0;
            // tbr=0 outside IDLE, so writes during a frame are dropped here.
            if (wr_tx && tbr) begin
               tx_shift <= databus;
               tbr      <= 1'b0;
            end
         end else begin
            if (baud_en) tx_tick <= tx_tick + 4'd1;
            if (tx_state == S_DATA && tx_last) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_bits  <= tx_bits + 3'd1;
            end
            if (tx_state == S_STOP && tx_last) tbr <= 1'b1;
         end
      end
   end

   always_comb begin
      case (tx_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = tx_shift[0];
         default: txd = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   logic       rx_s1, rx_s2, rx_prev;
   fsm_t       rx_state, rx_next;
   logic [3:0] rx_tick;
   logic [2:0] rx_bits;
   logic [7:0] rx_shift;
   logic [7:0] rx_buf;
   logic       overrun;
   logic       rx_fall, rx_half, rx_full, rx_done_ok;

   assign rx_fall    = rx_prev & ~rx_s2;
   assign rx_half    = baud_en && (rx_tick == 4'd7);
   assign rx_full    = baud_en && (rx_tick == 4'hF);
   assign rx_done_ok = (rx_state == S_STOP) && rx_full && rx_s2;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_fall)                      rx_next = S_START;
         // Mid-start sample: a high line means a glitch, not a frame.
         S_START: if (rx_half)                      rx_next = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_full && rx_bits == 3'd7)   rx_next = S_STOP;
         S_STOP:  if (rx_full)                      rx_next = S_IDLE;
         default:                                   rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
         rx_tick  <= 4'd0;
         rx_bits  <= 3'd0;
         rx_shift <= 8'd0;
         rx_buf   <= 8'd0;
         rda      <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_state <= rx_next;

         // Restart the tick count on entry to START and after the mid-start
         // sample, so later samples land in the middle of each bit.
         if (rx_state == S_IDLE || (rx_state == S_START && rx_half))
            rx_tick <= 4'd0;
         else if (baud_en)
            rx_tick <= rx_tick + 4'd1;

         if (rx_state == S_IDLE) rx_bits <= 3'd0;

         if (rx_state == S_DATA && rx_full) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bits  <= rx_bits + 3'd1;
         end

         if (rx_done_ok) rx_buf <= rx_shift;

         // A byte completing on the same edge as a buffer read wins.
         if (rx_done_ok)  rda <= 1'b1;
         else if (rd_rx)  rda <= 1'b0;

         // Setting beats a simultaneous status-read clear.
         if (rx_done_ok && rda && !rd_rx) overrun <= 1'b1;
         else if (rd_st)                  overrun <= 1'b0;
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      rdata = 8'h00;
      case (ioaddr)
         2'b00:   rdata = rx_buf;
         2'b01:   rdata = {5'b00000, overrun, tbr, rda};
         default: rdata = 8'h00;
      endcase
   end

   assign databus = rd_en ? rdata : 8'bzzzz_zzzz;

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Special-purpose asynchronous receiver/transmitter (SPART): the bus-slave peripheral directly downstream of the processor-side bus driver.
- The driver accesses it through the iocs/iorw/ioaddr/databus handshake:
  - programs a 16-bit baud divisor;
  - writes bytes to transmit;
  - reads received bytes.
- The block serialises bytes onto txd and deserialises rxd as 8N1 frames, using 16x oversampling.

Parameters:
- DB_RESET, 16'h0515, divisor buffer value after reset (2400 baud at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- iocs  input  1  chip select; a bus access occurs on every rising edge where iocs=1
- iorw  input  1  1=read (SPART drives databus), 0=write (driver drives databus)
- ioaddr  input  2  register select
- databus  inout  8  shared bidirectional data bus
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready
- txd  output  1  serial transmit line, idles high
- rxd  input  1  serial receive line, asynchronous

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high, sampled only on rising clk.
- Reset state:
  - rda=0, tbr=1, txd=1, overrun=0;
  - DB=DB_RESET, baud counter=DB_RESET;
  - TX and RX FSMs in IDLE; databus high-Z.
- Register map, writes (iocs=1, iorw=0):
  - ioaddr 00 = transmit buffer;
  - 10 = DB[7:0];
  - 11 = DB[15:8].
- Register map, reads (iocs=1, iorw=1):
  - ioaddr 00 = receive buffer;
  - 01 = status {5'b0, overrun, tbr, rda};
  - any other read returns 8'h00.
- Bus drive: databus is driven combinationally (same cycle) only while iocs=1 and iorw=1; otherwise high-Z. The driver captures read data on the edge that ends the strobe cycle.
- Write 01 is ignored.
- Baud generator:
  - 16-bit down-counter; emits a 1-cycle enable pulse when the count is 0, reloading DB at the same time. Enable period = DB+1 clocks.
  - A write to 10 or 11 updates that DB byte and reloads the counter with the new full DB on the same edge.
  - DB=0 gives an enable on every cycle.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Write 00 with tbr=1 latches the byte and sets tbr=0 on that edge; the FSM enters START with txd=0 from the next cycle.
  - Each bit lasts 16 enables.
  - DATA shifts 8 bits LSB first; STOP drives txd=1 for 16 enables.
  - At the end of STOP: tbr=1, FSM returns to IDLE.
  - Write 00 while tbr=0 is dropped; the frame in progress is unaffected. This makes a strobe held for several cycles load exactly once.
  - A write to DB mid-frame takes effect immediately; no protection is provided.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - rxd passes through a 2-flop synchroniser before use.
  - IDLE: a synchronised 1->0 transition enters START; the sample counter is cleared.
  - START: after 8 enables, sample. If 1, false start, return to IDLE. If 0, enter DATA.
  - DATA: sample every 16 enables, 8 bits, LSB first into the shift register.
  - STOP: sample after 16 enables.
    - If 1: copy to receive buffer and set rda=1. If rda was already 1, also set overrun=1 (old byte overwritten).
    - If 0: framing error; discard the byte and leave rda unchanged.
  - The FSM returns to IDLE after the stop sample either way.
- rda clear: cleared on every edge where iocs=1, iorw=1, ioaddr=00. rda therefore stays 1 throughout the read strobe cycle, and a strobe held for several cycles is idempotent.
- overrun clear: cleared on an edge reading ioaddr=01.
- Simultaneous events:
  - Completion of a new byte on the same edge as a read of 00: the new byte wins; rda stays 1 and overrun is not set.
  - Completion of a new byte on the same edge as a status read: overrun is set.
- Reset mid-frame: both FSMs abort to IDLE on the next edge; txd=1 immediately after that edge.
- TX and RX are fully independent; full-duplex operation is supported.

Test Plan:
- Reset, then read status -> databus=8'h02 (tbr=1, rda=0); txd=1; no enable pulse before DB_RESET+1=1302 cycles.
- Write 10<=8'h02 then 11<=8'h00; write 00<=8'hA5 -> tbr=0 next edge; txd sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 48 clocks; tbr=1 after stop; a write of 8'h3C issued while tbr=0 is not transmitted.
- With DB=2, loop txd->rxd and send 8'h5A -> rda=1 after the stop sample. A 2-cycle read (iorw=1 set one cycle before capture) returns 8'h5A and rda=0 afterwards; hold iocs/iorw/00 for 3 cycles -> no side effect beyond rda=0.
- Drive rxd low for 4 enables only -> false start, rda remains 0. Send a frame with stop bit 0 -> rda remains 0 and the buffer is unchanged.
- Receive 8'h11 and then 8'h22 without reading -> buffer=8'h22, status=8'h07; a status read clears overrun; the next status read returns 8'h03.
- Assert rst mid-TX and mid-RX frame -> txd=1, tbr=1, rda=0, DB=16'h0515 on the following cycle; a new frame then transmits correctly.
